// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bytelane
// Brief    : RV32 data memory with byte/half/word access, fault reporting and
//            optional wait states behind a req/ready handshake.
// Revision : 1.0
// ============================================================================
module dmem_bytelane #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        fault
);
    localparam int          c_AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_BYTES = 32'(DEPTH_WORDS * 4);

    // Request actually being served this cycle (live inputs or latched copy)
    logic        w_act;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_uns;
    logic [31:0] w_a;
    logic [31:0] w_wd;

    logic [31:0]     w_off;
    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic            w_fault;
    logic            w_commit;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;

    logic [31:0] r_mem [DEPTH_WORDS];

    assign w_off  = w_a - BASE_ADDR;
    assign w_idx  = w_off[c_AW+1:2];
    assign w_lane = w_off[1:0];

    assign w_fault = (w_off >= c_BYTES)
                   || (w_size == 2'b11)
                   || ((w_size == 2'b01) && w_a[0])
                   || ((w_size == 2'b10) && (w_a[1:0] != 2'b00));

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load  = w_word;
        w_wdata = w_wd;
        w_be    = 4'b1111;
        case (w_size)
            2'b00: begin
                w_load  = {{24{~w_uns & w_byte[7]}}, w_byte};
                w_wdata = {4{w_wd[7:0]}};
                w_be    = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_load  = {{16{~w_uns & w_half[15]}}, w_half};
                w_wdata = {2{w_wd[15:0]}};
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign w_commit = w_act & w_we & ~w_fault & ~reset;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign ready = w_act;
    assign fault = w_act & w_fault;
    assign rd    = (w_act & ~w_we & ~w_fault) ? w_load : 32'h0;

    generate
        if (WAIT_STATES == 0) begin : g_comb
            assign w_act  = req & ~reset;
            assign w_we   = we;
            assign w_size = size;
            assign w_uns  = uns;
            assign w_a    = a;
            assign w_wd   = wd;
        end else begin : g_fsm
            typedef enum logic [1:0] {
                ST_IDLE = 2'd0,
                ST_WAIT = 2'd1,
                ST_RESP = 2'd2
            } state_t;

            localparam logic [3:0] c_CNT_INIT =
                (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

            state_t      r_state;
            state_t      w_state_nxt;
            logic [3:0]  r_cnt;
            logic [3:0]  w_cnt_nxt;
            logic        r_we;
            logic [1:0]  r_size;
            logic        r_uns;
            logic [31:0] r_a;
            logic [31:0] r_wd;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_we    <= 1'b0;
                    r_size  <= 2'b00;
                    r_uns   <= 1'b0;
                    r_a     <= 32'h0;
                    r_wd    <= 32'h0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    if ((r_state == ST_IDLE) && req) begin
                        r_we   <= we;
                        r_size <= size;
                        r_uns  <= uns;
                        r_a    <= a;
                        r_wd   <= wd;
                    end
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    ST_IDLE: begin
                        if (req) begin
                            if (WAIT_STATES == 1) begin
                                w_state_nxt = ST_RESP;
                            end else begin
                                w_state_nxt = ST_WAIT;
                                w_cnt_nxt   = c_CNT_INIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
                        else               w_cnt_nxt   = r_cnt - 4'd1;
                    end
                    ST_RESP: w_state_nxt = ST_IDLE;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end

            assign w_act  = (r_state == ST_RESP) & ~reset;
            assign w_we   = r_we;
            assign w_size = r_size;
            assign w_uns  = r_uns;
            assign w_a    = r_a;
            assign w_wd   = r_wd;
        end
    endgenerate

endmodule
`default_nettype wire
